// File: rtl/alu_mul_req.sv
// Multiply request sequencer between the EXU and an external multiplier.
// It registers one op at a time, tracks flush/drain of the multiplier handshake and selects the result.
module alu_mul_req #(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mul_op_valid_i,
    input  logic [2:0]          mul_op_i,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic                flush_i,
    output logic                mul_valid_o,
    output logic                rs1_signed_valid_o,
    output logic                rs2_signed_valid_o,
    output logic [XLEN-1:0]     rs1_data_o,
    output logic [XLEN-1:0]     rs2_data_o,
    input  logic                mul_ready_i,
    input  logic [2*XLEN-1:0]   mul_out_i,
    output logic                mul_stall_o,
    output logic                result_valid_o,
    output logic [XLEN-1:0]     result_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic              rs1_sgn_q, rs1_sgn_d;
    logic              rs2_sgn_q, rs2_sgn_d;
    logic              mul_valid_q, mul_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              mul_stall_s;
    logic              result_valid_s;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_MULW);
    endfunction

    function automatic logic op_rs1_signed(input logic [2:0] op);
        logic sgn;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU: sgn = 1'b1;
            default:                    sgn = 1'b0;
        endcase
        return sgn;
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] op);
        logic sgn;
        case (op)
            OP_MUL, OP_MULH: sgn = 1'b1;
            default:         sgn = 1'b0;
        endcase
        return sgn;
    endfunction

    function automatic logic [XLEN-1:0] select_result(input logic [2:0] op,
                                                      input logic [2*XLEN-1:0] prod);
        logic [XLEN-1:0] res;
        case (op)
            OP_MUL:                      res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_MULW:                     res = {{(XLEN-32){prod[31]}}, prod[31:0]};
            default:                     res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // Next-state, operand capture and result capture
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rs1_sgn_d = rs1_sgn_q;
        rs2_sgn_d = rs2_sgn_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_op_valid_i && !flush_i) begin
                    if (op_is_legal(mul_op_i)) begin
                        op_d      = mul_op_i;
                        rs1_d     = rs1_data_i;
                        rs2_d     = rs2_data_i;
                        rs1_sgn_d = op_rs1_signed(mul_op_i);
                        rs2_sgn_d = op_rs2_signed(mul_op_i);
                        state_d   = ST_BUSY;
                    end else begin
                        // Reserved op: never reaches the multiplier, retires with a zero result
                        result_d = {XLEN{1'b0}};
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_ready_i) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        result_d = select_result(op_q, mul_out_i);
                        state_d  = ST_DONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DRAIN: begin
                if (mul_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mul_valid_d = (state_d == ST_BUSY) || (state_d == ST_DRAIN);
    end

    // Stall and result strobe depend on the live EXU inputs
    always_comb begin
        mul_stall_s    = 1'b0;
        result_valid_s = 1'b0;
        if (rst) begin
            mul_stall_s    = 1'b0;
            result_valid_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  mul_stall_s    = mul_op_valid_i & ~flush_i;
                ST_BUSY:  mul_stall_s    = ~flush_i;
                ST_DRAIN: mul_stall_s    = mul_op_valid_i;
                ST_DONE:  result_valid_s = ~flush_i;
                default: begin
                    mul_stall_s    = 1'b0;
                    result_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            rs1_q       <= {XLEN{1'b0}};
            rs2_q       <= {XLEN{1'b0}};
            rs1_sgn_q   <= 1'b0;
            rs2_sgn_q   <= 1'b0;
            mul_valid_q <= 1'b0;
            result_q    <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs1_sgn_q   <= rs1_sgn_d;
            rs2_sgn_q   <= rs2_sgn_d;
            mul_valid_q <= mul_valid_d;
            result_q    <= result_d;
        end
    end

    assign mul_valid_o        = mul_valid_q;
    assign rs1_signed_valid_o = rs1_sgn_q;
    assign rs2_signed_valid_o = rs2_sgn_q;
    assign rs1_data_o         = rs1_q;
    assign rs2_data_o         = rs2_q;
    assign mul_stall_o        = mul_stall_s;
    assign result_valid_o     = result_valid_s;
    assign result_o           = result_q;

endmodule

// File: tb/tb_alu_mul_req.sv
// Bench for alu_mul_req: EXU driver, multiplier responder and an arithmetic result model.
`timescale 1ns/1ps
module tb_alu_mul_req;
    localparam int XLEN = 64;

    logic              clk;
    logic              rst;
    logic              mul_op_valid_i;
    logic [2:0]        mul_op_i;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic              flush_i;
    logic              mul_valid_o;
    logic              rs1_signed_valid_o;
    logic              rs2_signed_valid_o;
    logic [XLEN-1:0]   rs1_data_o;
    logic [XLEN-1:0]   rs2_data_o;
    logic              mul_ready_i;
    logic [2*XLEN-1:0] mul_out_i;
    logic              mul_stall_o;
    logic              result_valid_o;
    logic [XLEN-1:0]   result_o;

    int total = 0;
    int bad = 0;
    int res_count = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_result = 64'd0;
    logic [2:0]  exp_op = 3'd0;
    logic [63:0] exp_a = 64'd0;
    logic [63:0] exp_b = 64'd0;
    int resp_delay = 0;
    bit resp_en = 1'b1;
    int inject_req = 0;

    alu_mul_req #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .mul_op_valid_i(mul_op_valid_i), .mul_op_i(mul_op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .mul_valid_o(mul_valid_o),
        .rs1_signed_valid_o(rs1_signed_valid_o), .rs2_signed_valid_o(rs2_signed_valid_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .mul_ready_i(mul_ready_i), .mul_out_i(mul_out_i),
        .mul_stall_o(mul_stall_o), .result_valid_o(result_valid_o), .result_o(result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of each op, straight from signed/unsigned arithmetic
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [63:0] a,
                                                 input logic [63:0] b);
        logic signed [127:0] sa, sb, ub_s, ss, su;
        logic [127:0] uu;
        logic [63:0] r;
        sa   = 128'($signed(a));
        sb   = 128'($signed(b));
        ub_s = {64'd0, b};
        ss   = sa * sb;
        su   = sa * ub_s;
        uu   = {64'd0, a} * {64'd0, b};
        case (op)
            3'd0:    r = uu[63:0];
            3'd1:    r = ss[127:64];
            3'd2:    r = su[127:64];
            3'd3:    r = uu[127:64];
            3'd4:    r = {{32{uu[31]}}, uu[31:0]};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic exp_sgn1(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2);
    endfunction

    function automatic logic exp_sgn2(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1);
    endfunction

    function automatic logic [127:0] hw_product(input logic [63:0] a, input logic [63:0] b,
                                                input logic sa, input logic sb);
        logic [127:0] ea, eb;
        ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    // Multiplier: answers a request after resp_delay cycles using the operands it was handed
    initial begin : responder
        int cnt;
        int inject_seen;
        cnt = 0;
        inject_seen = 0;
        mul_ready_i = 1'b0;
        mul_out_i = 128'd0;
        forever begin
            @(negedge clk);
            mul_ready_i = 1'b0;
            mul_out_i = {$urandom, $urandom, $urandom, $urandom};
            if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                mul_ready_i = 1'b1;
            end else if (mul_valid_o && resp_en) begin
                if (cnt >= resp_delay) begin
                    mul_ready_i = 1'b1;
                    mul_out_i = hw_product(rs1_data_o, rs2_data_o, rs1_signed_valid_o,
                                           rs2_signed_valid_o);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle compare: operand/signedness stability on requests, results against the model
    initial begin : compare
        logic prev_valid;
        logic [63:0] la, lb;
        logic [2:0] lop;
        prev_valid = 1'b0;
        la = 64'd0;
        lb = 64'd0;
        lop = 3'd0;
        forever begin
            @(posedge clk);
            #4;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (mul_valid_o) begin
                    if (!prev_valid) begin
                        la = exp_a;
                        lb = exp_b;
                        lop = exp_op;
                    end
                    check("rs1_data_o", 128'(rs1_data_o), 128'(la));
                    check("rs2_data_o", 128'(rs2_data_o), 128'(lb));
                    check("rs1_signed", 128'(rs1_signed_valid_o), 128'(exp_sgn1(lop)));
                    check("rs2_signed", 128'(rs2_signed_valid_o), 128'(exp_sgn2(lop)));
                end
                if (result_valid_o) begin
                    res_count++;
                    last_result = result_o;
                    if (exp_q.size() == 0) begin
                        check("result_valid_o spurious", 128'(result_valid_o), 128'd0);
                    end else begin
                        check("result_o", 128'(result_o), 128'(exp_q.pop_front()));
                    end
                end
                prev_valid = mul_valid_o;
            end
        end
    end

    task automatic present(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        mul_op_valid_i = 1'b1;
        mul_op_i = op;
        rs1_data_i = a;
        rs2_data_i = b;
        exp_op = op;
        exp_a = a;
        exp_b = b;
    endtask

    // EXU-side op: presented until stall drops; checks occupancy and single result strobe
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int delay, input int extra, input bit has_lit,
                          input logic [63:0] lit);
        int n;
        int rc0;
        int exp_n;
        @(negedge clk);
        flush_i = 1'b0;
        present(op, a, b);
        resp_delay = delay;
        exp_q.push_back(model_result(op, a, b));
        rc0 = res_count;
        exp_n = extra + ((op <= 3'd4) ? (delay + 3) : 2);
        n = 0;
        forever begin
            #1;
            n++;
            if (!mul_stall_o || n > 200) break;
            @(negedge clk);
        end
        check("op cycles", 128'(n), 128'(exp_n));
        check("result strobes", 128'(res_count - rc0), 128'd1);
        if (has_lit) check("result literal", 128'(last_result), 128'(lit));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " mul_valid_o"}, 128'(mul_valid_o), 128'd0);
        check({tag, " rs1_signed"}, 128'(rs1_signed_valid_o), 128'd0);
        check({tag, " rs2_signed"}, 128'(rs2_signed_valid_o), 128'd0);
        check({tag, " rs1_data_o"}, 128'(rs1_data_o), 128'd0);
        check({tag, " rs2_data_o"}, 128'(rs2_data_o), 128'd0);
        check({tag, " result_o"}, 128'(result_o), 128'd0);
        check({tag, " result_valid_o"}, 128'(result_valid_o), 128'd0);
        check({tag, " mul_stall_o"}, 128'(mul_stall_o), 128'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int rc0;
        logic [2:0] op;
        logic [63:0] a, b;
        rst = 1'b1;
        mul_op_valid_i = 1'b0;
        mul_op_i = 3'd0;
        rs1_data_i = 64'd0;
        rs2_data_i = 64'd0;
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Directed vectors with hand-computed results
        run_op(3'd0, 64'd3, 64'd5, 1, 0, 1'b1, 64'd15);
        run_op(3'd0, 64'd3, 64'd5, 0, 0, 1'b1, 64'd15);
        run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b1, 64'd0);
        run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2, 0, 1'b1, 64'd1);
        run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd6, 64'd9, 64'd9, 0, 0, 1'b1, 64'd0);
        run_op(3'd4, 64'h0000_0001_0000_0003, 64'd5, 1, 0, 1'b1, 64'h0000_0000_0000_000F);
        run_op(3'd1, 64'h8000_0000_0000_0000, 64'd2, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd3, 64'h8000_0000_0000_0000, 64'd2, 4, 0, 1'b1, 64'd1);

        // Flush in second BUSY cycle: request drains, next op waits for IDLE
        @(negedge clk);
        present(3'd0, 64'd7, 64'd9);
        resp_delay = 6;
        #1 check("issue stall", 128'(mul_stall_o), 128'd1);
        @(negedge clk);
        #1 check("busy1 mul_valid_o", 128'(mul_valid_o), 128'd1);
        @(negedge clk);
        flush_i = 1'b1;
        #1 check("busy flush stall", 128'(mul_stall_o), 128'd0);
        run_op(3'd0, 64'd2, 64'd3, 6, 5, 1'b1, 64'd6);

        // Flush together with ready: back to IDLE, nothing reported
        @(negedge clk);
        rc0 = res_count;
        present(3'd3, 64'd5, 64'd5);
        resp_delay = 1;
        @(negedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        mul_op_valid_i = 1'b0;
        #1 check("flush+ready mul_valid_o", 128'(mul_valid_o), 128'd0);
        check("flush+ready stall", 128'(mul_stall_o), 128'd0);
        @(negedge clk);
        check("flush+ready strobes", 128'(res_count - rc0), 128'd0);

        // Flush in DONE masks the strobe
        rc0 = res_count;
        present(3'd0, 64'd4, 64'd4);
        resp_delay = 0;
        @(negedge clk);
        @(posedge clk);
        #2 flush_i = 1'b1;
        #1 check("done flush mask", 128'(result_valid_o), 128'd0);
        @(negedge clk);
        flush_i = 1'b0;
        mul_op_valid_i = 1'b0;
        #1 check("after done mul_valid_o", 128'(mul_valid_o), 128'd0);
        @(negedge clk);
        check("done flush strobes", 128'(res_count - rc0), 128'd0);

        // Reset while BUSY, then a late ready pulse
        rc0 = res_count;
        resp_en = 1'b0;
        present(3'd0, 64'd11, 64'd13);
        @(negedge clk);
        @(negedge clk);
        check("pre-reset mul_valid_o", 128'(mul_valid_o), 128'd1);
        rst = 1'b1;
        #1 check_outputs_zero("mid-busy reset");
        @(negedge clk);
        mul_op_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
        inject_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("post-reset mul_valid_o", 128'(mul_valid_o), 128'd0);
            check("post-reset result_valid_o", 128'(result_valid_o), 128'd0);
        end
        check("post-reset strobes", 128'(res_count - rc0), 128'd0);

        // Back-to-back ops with random multiplier latency
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 15) == 0) op = 3'($urandom_range(5, 7));
            else op = 3'($urandom_range(0, 4));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: a = 64'hFFFF_FFFF_FFFF_FFFF;
                1: b = 64'h8000_0000_0000_0000;
                2: a = 64'h0000_0000_8000_0000;
                default: a = a;
            endcase
            run_op(op, a, b, int'($urandom_range(0, 20)), 0, 1'b0, 64'd0);
        end
        @(negedge clk);
        mul_op_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("results outstanding", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_req.md
ALU_MUL_REQ -- requirements
Module: alu_mul_req

Interface
REQ-001 Parameter XLEN, 64, operand/result width; product width 2*XLEN.
REQ-002 clk  input  1  system clock, all state rises on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mul_op_valid_i  input  1  EXU presents a multiply op, held stable while mul_stall_o=1.
REQ-005 mul_op_i  input  3  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU, 4=MULW; 5-7 reserved.
REQ-006 rs1_data_i / rs2_data_i  input  XLEN each  EXU operands.
REQ-007 flush_i  input  1  pipeline flush; kill current op.
REQ-008 mul_valid_o  output  1  request to multiplier.
REQ-009 rs1_signed_valid_o / rs2_signed_valid_o  output  1 each  operand signedness to multiplier.
REQ-010 rs1_data_o / rs2_data_o  output  XLEN each  registered operands to multiplier.
REQ-011 mul_ready_i  input  1  multiplier done; mul_out_i valid this cycle only.
REQ-012 mul_out_i  input  2*XLEN  full product.
REQ-013 mul_stall_o  output  1  EXU must hold.
REQ-014 result_valid_o  output  1  one-cycle result strobe.
REQ-015 result_o  output  XLEN  selected result.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, DRAIN, DONE, state registered.
REQ-017 IDLE with mul_op_valid_i=1, flush_i=0, mul_op_i<=4 SHALL capture operands, signedness, op into registers and go BUSY next cycle.
REQ-018 Signedness SHALL be MUL/MULH 1/1, MULHSU 1/0, MULHU 0/0, MULW 0/0.
REQ-019 Reserved mul_op_i SHALL not issue; result_valid_o pulses next cycle with result_o=0.
REQ-020 mul_valid_o SHALL equal 1 exactly in BUSY and DRAIN; operands and signedness stable throughout.
REQ-021 BUSY with mul_ready_i=1 SHALL register result and go DONE; BUSY with flush_i=1 and mul_ready_i=0 SHALL go DRAIN; flush_i and mul_ready_i together SHALL go IDLE, result discarded.
REQ-022 DRAIN SHALL hold mul_valid_o=1 until mul_ready_i=1, then IDLE, result discarded.
REQ-023 DONE SHALL assert result_valid_o=1 for exactly one cycle (masked to 0 if flush_i=1), then IDLE unconditionally; mul_op_valid_i in DONE SHALL not issue.
REQ-024 Result select: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; MULW sign-extension of bits [31:0].
REQ-025 mul_stall_o SHALL be 1 when (IDLE and mul_op_valid_i and not flush_i) or (BUSY and not flush_i) or (DRAIN and mul_op_valid_i); else 0.
REQ-026 mul_ready_i in IDLE or DONE SHALL be ignored.
REQ-027 Minimum latency: issue cycle N, mul_valid_o at N+1, ready at N+1 gives result_valid_o at N+2.
REQ-028 Back-to-back ops SHALL issue from IDLE the cycle after DONE; no request lost.

Reset
REQ-029 rst=1 SHALL force state IDLE immediately; mul_valid_o, signedness, result_valid_o, mul_stall_o, rs1/rs2_data_o, result_o to 0.
REQ-030 Reset mid-BUSY SHALL abandon the outstanding request; late mul_ready_i after release SHALL be ignored.

Verification
REQ-031 MUL 3*5, ready 1 cycle after valid -> result_o=15, result_valid_o one cycle, stall released same cycle.
REQ-032 MULH -1*-1 (mul_out=128'h1) -> result_o=0; MULHU 64'hFFFF_FFFF_FFFF_FFFF*2 -> result_o=1; MULHSU -1*2 -> result_o=64'hFFFF_FFFF_FFFF_FFFF.
REQ-033 MULW 32'h7FFF_FFFF*2 -> result_o=64'hFFFF_FFFF_FFFF_FFFE, signedness 0/0.
REQ-034 Flush at 2nd BUSY cycle, ready after 5 more -> mul_valid_o held until ready, no result_valid_o, new op issued only after return to IDLE.
REQ-035 Random ready delay 0-20 cycles, 1000 back-to-back ops vs reference model -> all results match, operands stable while mul_valid_o=1.
REQ-036 rst asserted in BUSY, ready pulse after release -> all outputs 0, no result_valid_o.
